// File: rtl/ctrl_link_pkg.sv
// Shared constants and types for the byte-oriented control link
// (command frames out, response frames in).
package ctrl_link_pkg;
    localparam logic [7:0] COMMA_K       = 8'h3C;
    localparam int         CMD_FRAME_LEN = 8;
    localparam int         RSP_FRAME_LEN = 6;

    localparam logic [2:0] FLAGS   = 3'd1;
    localparam logic [2:0] ADDR_LO = 3'd2;
    localparam logic [2:0] DATA0   = 3'd4;

    localparam int STROBE_BIT = 0;
    localparam int WRITE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic        strobe;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cmd_t;
endpackage

// File: rtl/ctrl_link_rsp_parser.sv
// Response-frame parser: COMMA, ack byte, then 32-bit data LSB first.
// Commits ack/data with a one-cycle rx_frame_ok on the last data byte.
module ctrl_link_rsp_parser
    import ctrl_link_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_K
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_isk,
    input  logic        link_ok,
    output logic        rx_ack,
    output logic [31:0] rx_data,
    output logic        rx_frame_ok
);
    // idx counts bytes after the comma: 0 = ack byte, LAST_IDX = data MSB
    localparam logic [2:0] LAST_IDX = 3'(RSP_FRAME_LEN - 2);

    logic [2:0]  idx;
    logic        in_frame;
    logic        ack_bit;
    logic [23:0] data_lo;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            in_frame    <= 1'b0;
            ack_bit     <= 1'b0;
            data_lo     <= '0;
            rx_ack      <= 1'b0;
            rx_data     <= '0;
            rx_frame_ok <= 1'b0;
        end else begin
            rx_frame_ok <= 1'b0;
            if (!link_ok) begin
                in_frame <= 1'b0;
                rx_ack   <= 1'b0;
            end else if (rx_isk) begin
                // A comma (re)starts a frame; any other K-char kills it
                in_frame <= (rx_byte == COMMA);
                idx      <= '0;
            end else if (in_frame) begin
                idx <= idx + 3'd1;
                if (idx == 3'd0) begin
                    ack_bit <= rx_byte[0];
                end else if (idx == LAST_IDX) begin
                    rx_ack      <= ack_bit;
                    rx_data     <= {rx_byte, data_lo};
                    rx_frame_ok <= 1'b1;
                    in_frame    <= 1'b0;
                end else begin
                    data_lo <= {rx_byte, data_lo[23:8]};
                end
            end
        end
    end
endmodule

// File: rtl/control_link_master.sv
// Initiator end of the control link: frames host requests into 8-byte
// command frames and runs the strobe/ack handshake with the remote slave.
module control_link_master
    import ctrl_link_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] COMMA          = COMMA_K
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  tx_byte,
    output logic        tx_isk,
    input  logic [7:0]  rx_byte,
    input  logic        rx_isk,
    input  logic        link_ok,
    output logic        busy
);
    localparam logic [2:0] PTR_LAST  = 3'(CMD_FRAME_LEN - 1);
    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    state_t       state;
    cmd_t         cmd_q;
    cmd_t         snap;
    logic [2:0]   ptr;
    logic [TW-1:0] timer;
    logic [7:0]   frame_byte;
    logic [7:0]   flags;
    logic         rx_ack;
    logic [31:0]  rx_data;
    logic         rx_frame_ok;
    logic         abort;

    ctrl_link_rsp_parser #(.COMMA(COMMA)) u_rsp_parser (
        .byte_clk    (byte_clk),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .rx_isk      (rx_isk),
        .link_ok     (link_ok),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_frame_ok (rx_frame_ok)
    );

    // Gated by reset so the host never sees a ready while the block is held
    assign req_ready = !reset && (state == ST_IDLE) && link_ok && !rx_ack && !rsp_valid;
    assign busy      = (state != ST_IDLE);
    assign abort     = !link_ok || (timer == TIMER_MAX);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        frame_byte            = 8'h00;
        flags                 = 8'h00;
        flags[WRITE_BIT]      = snap.write;
        flags[STROBE_BIT]     = snap.strobe;
        case (ptr)
            3'd0:           frame_byte = COMMA;
            FLAGS:          frame_byte = flags;
            ADDR_LO:        frame_byte = snap.addr[7:0];
            ADDR_LO + 3'd1: frame_byte = snap.addr[15:8];
            DATA0:          frame_byte = snap.wdata[7:0];
            DATA0 + 3'd1:   frame_byte = snap.wdata[15:8];
            DATA0 + 3'd2:   frame_byte = snap.wdata[23:16];
            DATA0 + 3'd3:   frame_byte = snap.wdata[31:24];
            default:        frame_byte = 8'h00;
        endcase
    end

    // Free-running framer; fields are frozen at the last byte of each frame
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            snap    <= '0;
            tx_byte <= COMMA;
            tx_isk  <= 1'b1;
        end else begin
            ptr     <= (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
            tx_byte <= frame_byte;
            tx_isk  <= (ptr == 3'd0);
            if (ptr == PTR_LAST) snap <= cmd_q;
        end
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd_q.write  <= req_write;
                        cmd_q.addr   <= req_addr;
                        cmd_q.wdata  <= req_write ? req_wdata : 32'h0;
                        cmd_q.strobe <= 1'b1;
                        timer        <= '0;
                        state        <= ST_ASSERT;
                    end
                end
                ST_ASSERT, ST_RELEASE: begin
                    if (abort) begin
                        cmd_q.strobe <= 1'b0;
                        cmd_q.write  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (state == ST_ASSERT && rx_frame_ok && rx_ack) begin
                        rsp_rdata    <= rx_data;
                        cmd_q.strobe <= 1'b0;
                        timer        <= '0;
                        state        <= ST_RELEASE;
                    end else if (state == ST_RELEASE && rx_frame_ok && !rx_ack) begin
                        cmd_q.write  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
